// File: rtl/ram_burst_master.sv
// Burst initiator for the single-port synchronous RAM: write bursts stream into the RAM,
// read bursts stream back out through a 2-entry FIFO that tolerates backpressure.
module ram_burst_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [ADDR_WIDTH-1:0] cur_addr_r, cur_addr_s;
  logic [ADDR_WIDTH-1:0] beats_left_r, beats_left_s;
  logic                  pending_r, pending_s;
  logic                  done_r, done_s;
  logic [DATA_WIDTH-1:0] fifo_r [2];
  logic                  head_r;
  logic [1:0]            occ_r;
  logic                  push_s, pop_s, room_s;

  assign pop_s  = (occ_r != 2'd0) && rd_ready;
  assign push_s = pending_r;
  // Slots committed next cycle (stored + in flight - leaving) must stay below 2.
  assign room_s = ({1'b0, occ_r} + {2'b00, pending_r}) < (3'd2 + {2'b00, pop_s});

  assign rd_valid = (occ_r != 2'd0);
  assign rd_data  = fifo_r[head_r];
  assign busy     = (state_r != IDLE);
  assign done     = done_r;

  // Next-state, address/beat bookkeeping and RAM-side strobes.
  always_comb begin
    state_s      = state_r;
    cur_addr_s   = cur_addr_r;
    beats_left_s = beats_left_r;
    pending_s    = 1'b0;
    done_s       = 1'b0;
    cmd_ready    = 1'b0;
    wr_ready     = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = cur_addr_r;
    ram_din      = {DATA_WIDTH{1'b0}};
    case (state_r)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_s   = cmd_addr;
          beats_left_s = cmd_len;
          state_s      = cmd_write ? WRITE : READ;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid) begin
          ram_we       = 1'b1;
          ram_din      = wr_data;
          cur_addr_s   = cur_addr_r + ADDR_WIDTH'(1);
          beats_left_s = beats_left_r - ADDR_WIDTH'(1);
          if (beats_left_r == {ADDR_WIDTH{1'b0}}) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = WRITE;
          end
        end else begin
          state_s = WRITE;
        end
      end
      READ: begin
        if (room_s) begin
          pending_s    = 1'b1;
          cur_addr_s   = cur_addr_r + ADDR_WIDTH'(1);
          beats_left_s = beats_left_r - ADDR_WIDTH'(1);
          if (beats_left_r == {ADDR_WIDTH{1'b0}}) begin
            state_s = DRAIN;
          end else begin
            state_s = READ;
          end
        end else begin
          state_s = READ;
        end
      end
      DRAIN: begin
        if (!pending_r && (occ_r == 2'd0)) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cur_addr_r   <= {ADDR_WIDTH{1'b0}};
      beats_left_r <= {ADDR_WIDTH{1'b0}};
      pending_r    <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cur_addr_r   <= cur_addr_s;
      beats_left_r <= beats_left_s;
      pending_r    <= pending_s;
      done_r       <= done_s;
    end
  end

  // Read-data FIFO; a push only ever lands when at most one entry is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_r[0] <= {DATA_WIDTH{1'b0}};
      fifo_r[1] <= {DATA_WIDTH{1'b0}};
      head_r    <= 1'b0;
      occ_r     <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_r[head_r ^ occ_r[0]] <= ram_dout;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      occ_r <= occ_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

endmodule

// File: tb/tb_ram_burst_master.sv
// Randomized self-checking bench for ram_burst_master with a behavioural RAM and a
// reference memory image that predicts every written address/data and every read beat.
module tb_ram_burst_master;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr, cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [DW-1:0] rd_data;
  logic          busy, done, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  int total = 0;
  int bad   = 0;

  ram_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode: 0 = full rate, 1 = toggling valid, 2 = random, 3 = rd_ready low in cycles 3..9
  task automatic run_burst(input bit wr, input logic [AW-1:0] addr, input logic [AW-1:0] len,
                           input int mode, input int abort_after);
    int beats, k, dones, first_hs, last_hs, first_valid, cyc;
    logic [AW-1:0] ea;
    beats = int'(len) + 1;
    k = 0; dones = 0; first_hs = -1; last_hs = -1; first_valid = -1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (cyc = 1; cyc < 300 && dones == 0; cyc++) begin
      if (wr) begin
        wr_valid = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
        wr_data  = (mode == 0) ? DW'(8'hA0 + k) : DW'($urandom);
      end else begin
        rd_ready = (mode == 0) ? 1'b1 : (mode == 3) ? !(cyc >= 3 && cyc <= 9)
                                                    : 1'($urandom_range(0, 1));
      end
      #1;
      ea = addr + AW'(k);
      if (k < beats) chk("busy", 32'(busy), 32'd1);
      if (done) begin
        dones++;
        chk("done_after_all_beats", 32'(k), 32'(beats));
        if (wr) chk("wr_done_latency", 32'(cyc), 32'(last_hs + 1));
      end
      if (wr) begin
        chk("ram_we", 32'(ram_we), 32'(wr_valid && k < beats));
        if (ram_we) begin
          chk("wr_addr", 32'(ram_addr), 32'(ea));
          chk("wr_data", 32'(ram_din), 32'(wr_data));
          ref_mem[ea] = wr_data;
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          k++;
        end
      end else begin
        chk("rd_no_write", 32'(ram_we), 32'd0);
        if (k >= beats) chk("rd_no_extra", 32'(rd_valid), 32'd0);
        if (rd_valid && first_valid < 0) first_valid = cyc;
        if (rd_valid && rd_ready && k < beats) begin
          chk("rd_data", 32'(rd_data), 32'(ref_mem[ea]));
          if (first_hs < 0) first_hs = cyc;
          last_hs = cyc;
          k++;
          if (abort_after > 0 && k == abort_after) begin
            rst_n = 1'b0;
            #1;
            chk("abort_rd_valid", 32'(rd_valid), 32'd0);
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
            chk("abort_done", 32'(done), 32'd0);
            @(negedge clk);
            rd_ready = 1'b0;
            rst_n = 1'b1;
            return;
          end
        end
      end
      @(negedge clk);
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    #1;
    chk("done_seen", 32'(dones), 32'd1);
    chk("done_single_cycle", 32'(done), 32'd0);
    chk("idle_after_done", 32'(busy), 32'd0);
    if (mode == 0) begin
      chk("first_beat_cycle", 32'(wr ? first_hs : first_valid), wr ? 32'd1 : 32'd3);
      chk("full_rate", 32'(last_hs - first_hs), 32'(len));
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]     = DW'($urandom);
      ref_mem[i] = ram[i];
    end
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_din", 32'(ram_din), 32'd0);
    rst_n = 1'b1;

    run_burst(1'b1, 4'h2, 4'd3, 0, 0);
    run_burst(1'b0, 4'h2, 4'd3, 0, 0);
    run_burst(1'b1, 4'hE, 4'd3, 0, 0);
    run_burst(1'b0, 4'hE, 4'd3, 0, 0);
    run_burst(1'b0, 4'h0, 4'd7, 3, 0);
    run_burst(1'b1, 4'h5, 4'd3, 1, 0);
    run_burst(1'b0, 4'h5, 4'd3, 0, 0);
    run_burst(1'b1, 4'h7, 4'd15, 2, 0);
    run_burst(1'b0, 4'h7, 4'd15, 0, 0);
    run_burst(1'b0, 4'h3, 4'd15, 2, 0);
    for (int n = 0; n < 8; n++) begin
      run_burst(1'($urandom_range(0, 1)), AW'($urandom), AW'($urandom), 2, 0);
    end
    for (int i = 0; i < DEPTH; i++) chk("ram_image", 32'(ram[i]), 32'(ref_mem[i]));
    run_burst(1'b0, 4'h8, 4'd7, 0, 3);
    run_burst(1'b0, 4'h0, 4'd0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
